// File: rtl/crypt_seq.sv
// Block XOR copy engine: reads BLOCK_LEN words from src, writes word ^ KEY to dst (3 cycles/word at full grant, done 3*BLOCK_LEN+1 cycles after start).
// Backpressure: each request holds its address, direction and data stable until mem_gnt; start is ignored while busy.
module crypt_seq #(
    parameter logic [18:0] KEY       = 19'b0011001100110011111,
    parameter int          BLOCK_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [18:0] src_addr,
    input  logic [18:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic        op_mode,
    output logic        mem_req,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [18:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic [18:0] mem_rdata
);
    localparam int            IW   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [18:0]   src, src_nx, dst, dst_nx;
    logic          busy_nx, done_nx, op_mode_nx, req_nx, we_nx;
    logic [18:0]   addr_nx, wdata_nx;
    logic [18:0]   idx_ext, idx_inc_ext;

    // Address sums are 19 bits wide, so src + i and dst + i wrap naturally.
    assign idx_ext     = 19'(idx);
    assign idx_inc_ext = 19'(idx) + 19'd1;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        src_nx     = src;
        dst_nx     = dst;
        busy_nx    = busy;
        done_nx    = 1'b0;
        op_mode_nx = op_mode;
        req_nx     = mem_req;
        we_nx      = mem_we;
        addr_nx    = mem_addr;
        wdata_nx   = mem_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    src_nx     = src_addr;
                    dst_nx     = dst_addr;
                    op_mode_nx = mode;
                    idx_nx     = '0;
                    busy_nx    = 1'b1;
                    req_nx     = 1'b1;
                    we_nx      = 1'b0;
                    addr_nx    = src_addr;
                    state_nx   = RD;
                end
            end
            RD: begin
                if (mem_gnt) begin
                    req_nx   = 1'b0;
                    state_nx = CAP;
                end
            end
            CAP: begin
                // mem_wdata doubles as the captured data register.
                wdata_nx = mem_rdata ^ KEY;
                req_nx   = 1'b1;
                we_nx    = 1'b1;
                addr_nx  = dst + idx_ext;
                state_nx = WR;
            end
            WR: begin
                if (mem_gnt) begin
                    we_nx = 1'b0;
                    if (idx == LAST) begin
                        req_nx   = 1'b0;
                        state_nx = FIN;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        req_nx   = 1'b1;
                        addr_nx  = src + idx_inc_ext;
                        state_nx = RD;
                    end
                end
            end
            FIN: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            src       <= '0;
            dst       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_mode   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            src       <= src_nx;
            dst       <= dst_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            op_mode   <= op_mode_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
        end
    end
endmodule
